// File: rtl/win_conv_filter.sv
// Per-lane 2-D convolution over WIN_SIZE x WIN_SIZE windows with a 3-stage pipeline.
// Kernel updates are staged in a pending register and committed on the first valid frame-start beat.
module win_conv_filter #(
    parameter int unsigned PX_WIDTH   = 12,
    parameter int unsigned PX_PER_CLK = 4,
    parameter int unsigned WIN_SIZE   = 3,
    parameter int unsigned COEF_WIDTH = 8,
    parameter int unsigned FRAC_BITS  = 4
) (
    input  logic                                                      clk_i,
    input  logic                                                      rst_n_i,
    input  logic [PX_PER_CLK-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][PX_WIDTH-1:0] win_data_i,
    input  logic [PX_PER_CLK-1:0]                                     win_data_val_i,
    input  logic                                                      line_start_i,
    input  logic                                                      line_end_i,
    input  logic                                                      frame_start_i,
    input  logic                                                      frame_end_i,
    input  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][COEF_WIDTH-1:0]         coef_i,
    input  logic                                                      coef_wr_i,
    output logic                                                      coef_pending_o,
    output logic [PX_PER_CLK-1:0][PX_WIDTH-1:0]                       px_data_o,
    output logic [PX_PER_CLK-1:0]                                     px_data_val_o,
    output logic                                                      line_start_o,
    output logic                                                      line_end_o,
    output logic                                                      frame_start_o,
    output logic                                                      frame_end_o
);

    localparam int unsigned NumTaps = WIN_SIZE * WIN_SIZE;
    localparam int unsigned ProdW   = PX_WIDTH + 1 + COEF_WIDTH;
    localparam int unsigned SumW    = ProdW + $clog2(NumTaps);
    localparam int unsigned RndW    = SumW + 1;
    localparam int unsigned Ctr     = WIN_SIZE / 2;

    localparam logic signed [RndW-1:0] RndBias =
        (FRAC_BITS > 0) ? (RndW'(1) << (FRAC_BITS - 1)) : '0;
    localparam logic signed [RndW-1:0] PxMax = RndW'((1 << PX_WIDTH) - 1);

    typedef logic [WIN_SIZE-1:0][WIN_SIZE-1:0][COEF_WIDTH-1:0] kernel_t;
    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e  state_q, state_d;
    kernel_t pend_q, pend_d;
    kernel_t act_q, act_d;
    kernel_t kern_use;
    logic    apply;

    // ---------------- Kernel control ----------------
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        act_d   = act_q;
        apply   = 1'b0;
        if ((state_q == StPending) && frame_start_i && (|win_data_val_i)) begin
            apply   = 1'b1;
            act_d   = pend_q;
            state_d = StIdle;
        end
        // A write on the apply beat re-arms pending for the next frame.
        if (coef_wr_i) begin
            pend_d  = coef_i;
            state_d = StPending;
        end
    end

    // The apply beat itself already uses the new kernel.
    assign kern_use = apply ? pend_q : act_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q           <= StIdle;
            pend_q            <= '0;
            act_q             <= '0;
            act_q[Ctr][Ctr]   <= COEF_WIDTH'(1 << FRAC_BITS);
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
        end
    end

    // ---------------- S1: products ----------------
    logic signed [ProdW-1:0] prod_d [PX_PER_CLK][WIN_SIZE][WIN_SIZE];
    logic signed [ProdW-1:0] prod_q [PX_PER_CLK][WIN_SIZE][WIN_SIZE];
    logic [PX_PER_CLK-1:0]   val1_q, val2_q, val3_q;
    logic [3:0]              sb_in, sb1_q, sb2_q, sb3_q;

    always_comb begin
        for (int l = 0; l < PX_PER_CLK; l++) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE; c++) begin
                    if (win_data_val_i[l]) begin
                        prod_d[l][r][c] = ProdW'($signed({1'b0, win_data_i[l][r][c]}))
                                        * ProdW'($signed(kern_use[r][c]));
                    end else begin
                        prod_d[l][r][c] = '0;
                    end
                end
            end
        end
    end

    // ---------------- S2: sums ----------------
    logic signed [SumW-1:0] sum_d [PX_PER_CLK];
    logic signed [SumW-1:0] sum_q [PX_PER_CLK];

    always_comb begin
        for (int l = 0; l < PX_PER_CLK; l++) begin
            sum_d[l] = '0;
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE; c++) begin
                    sum_d[l] = sum_d[l] + SumW'(prod_q[l][r][c]);
                end
            end
        end
    end

    // ---------------- S3: round, shift, clamp ----------------
    logic [PX_PER_CLK-1:0][PX_WIDTH-1:0] px_d, px_q;
    logic signed [RndW-1:0]              rnd;
    logic signed [RndW-1:0]              shf;

    always_comb begin
        px_d = '0;
        rnd  = '0;
        shf  = '0;
        for (int l = 0; l < PX_PER_CLK; l++) begin
            rnd = RndW'(sum_q[l]) + RndBias;
            shf = rnd >>> FRAC_BITS;
            if (!val2_q[l] || shf[RndW-1]) begin
                px_d[l] = '0;
            end else if (shf > PxMax) begin
                px_d[l] = '1;
            end else begin
                px_d[l] = shf[PX_WIDTH-1:0];
            end
        end
    end

    assign sb_in = {frame_end_i, frame_start_i, line_end_i, line_start_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int l = 0; l < PX_PER_CLK; l++) begin
                sum_q[l] <= '0;
                for (int r = 0; r < WIN_SIZE; r++) begin
                    for (int c = 0; c < WIN_SIZE; c++) begin
                        prod_q[l][r][c] <= '0;
                    end
                end
            end
            px_q   <= '0;
            val1_q <= '0;
            val2_q <= '0;
            val3_q <= '0;
            sb1_q  <= '0;
            sb2_q  <= '0;
            sb3_q  <= '0;
        end else begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
            px_q   <= px_d;
            val1_q <= win_data_val_i;
            val2_q <= val1_q;
            val3_q <= val2_q;
            sb1_q  <= sb_in;
            sb2_q  <= sb1_q;
            sb3_q  <= sb2_q;
        end
    end

    assign coef_pending_o = (state_q == StPending);
    assign px_data_o      = px_q;
    assign px_data_val_o  = val3_q;
    assign line_start_o   = sb3_q[0];
    assign line_end_o     = sb3_q[1];
    assign frame_start_o  = sb3_q[2];
    assign frame_end_o    = sb3_q[3];

endmodule

// File: tb/tb_win_conv_filter.sv
// Directed bench for win_conv_filter: arithmetic, saturation, rounding, kernel staging, reset.
module tb_win_conv_filter;

    typedef logic [3:0][2:0][2:0][11:0] win_t;
    typedef logic [2:0][2:0][7:0]        kern_t;

    logic        clk;
    logic        rst_n;
    win_t        win_data;
    logic [3:0]  win_val;
    logic        ls, le, fs, fe;
    kern_t       coef;
    logic        coef_wr;
    logic        pending;
    logic [3:0][11:0] px;
    logic [3:0]  px_val;
    logic        ls_o, le_o, fs_o, fe_o;

    int checks = 0;
    int errors = 0;

    win_conv_filter dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .win_data_i     (win_data),
        .win_data_val_i (win_val),
        .line_start_i   (ls),
        .line_end_i     (le),
        .frame_start_i  (fs),
        .frame_end_i    (fe),
        .coef_i         (coef),
        .coef_wr_i      (coef_wr),
        .coef_pending_o (pending),
        .px_data_o      (px),
        .px_data_val_o  (px_val),
        .line_start_o   (ls_o),
        .line_end_o     (le_o),
        .frame_start_o  (fs_o),
        .frame_end_o    (fe_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic win_t fill(input logic [11:0] v);
        win_t w;
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[l][r][c] = v;
        return w;
    endfunction

    function automatic kern_t kall(input logic [7:0] k);
        kern_t t;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                t[r][c] = k;
        return t;
    endfunction

    function automatic kern_t kctr(input logic [7:0] k);
        kern_t t;
        t = '0;
        t[1][1] = k;
        return t;
    endfunction

    // Called at a negedge; inputs are seen by exactly one rising edge.
    task automatic drive_beat(input win_t w, input logic [3:0] v, input logic [3:0] sb);
        win_data = w;
        win_val  = v;
        {fe, fs, le, ls} = sb;
        @(negedge clk);
        win_data = '0;
        win_val  = '0;
        {fe, fs, le, ls} = '0;
    endtask

    // After drive_beat, two more negedges land just after the third edge.
    task automatic wait_out();
        repeat (2) @(negedge clk);
    endtask

    task automatic write_coef(input kern_t k);
        coef    = k;
        coef_wr = 1'b1;
        @(negedge clk);
        coef_wr = 1'b0;
    endtask

    win_t w;

    initial begin
        rst_n    = 1'b0;
        win_data = '0;
        win_val  = '0;
        {fe, fs, le, ls} = '0;
        coef     = '0;
        coef_wr  = 1'b0;

        // Reset state
        #12;
        check("rst_px", 64'(px), 64'h0);
        check("rst_val", 64'(px_val), 64'h0);
        check("rst_pending", 64'(pending), 64'h0);
        check("rst_sb", 64'({fe_o, fs_o, le_o, ls_o}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Identity pass-through and 3-cycle latency
        w = '0;
        w[0][1][1] = 12'hABC;
        drive_beat(w, 4'b0001, 4'b0101);
        @(negedge clk);
        check("lat_sb_early", 64'({fe_o, fs_o, le_o, ls_o}), 64'h0);
        check("lat_val_early", 64'(px_val), 64'h0);
        @(negedge clk);
        check("ident_px0", 64'(px[0]), 64'hABC);
        check("ident_val", 64'(px_val), 64'h1);
        check("ident_sb", 64'({fe_o, fs_o, le_o, ls_o}), 64'h5);

        // 2. Box kernel applied on frame-start beat
        write_coef(kall(8'h10));
        check("box_pending", 64'(pending), 64'h1);
        drive_beat(fill(12'h100), 4'b1111, 4'b0100);
        check("box_pending_clr", 64'(pending), 64'h0);
        wait_out();
        check("box_px", 64'(px), {16'h0, 12'h900, 12'h900, 12'h900, 12'h900});
        check("box_val", 64'(px_val), 64'hF);

        // 3. Saturation high and low
        drive_beat(fill(12'hFFF), 4'b0001, 4'b0000);
        wait_out();
        check("sat_hi", 64'(px[0]), 64'hFFF);
        write_coef(kctr(8'hF0));
        drive_beat(fill(12'h005), 4'b0001, 4'b0100);
        wait_out();
        check("sat_lo", 64'(px[0]), 64'h000);
        check("sat_lo_val", 64'(px_val), 64'h1);

        // 4. Rounding: 3 * 0.5 = 1.5 -> 2
        write_coef(kctr(8'h08));
        drive_beat(fill(12'h003), 4'b0001, 4'b0100);
        wait_out();
        check("round", 64'(px[0]), 64'h002);

        // 5. Mid-frame write is held until next valid frame start
        write_coef(kall(8'h10));
        check("mid_pending", 64'(pending), 64'h1);
        drive_beat(fill(12'h100), 4'b0001, 4'b0000);
        wait_out();
        check("mid_unchanged", 64'(px[0]), 64'h080);
        drive_beat(fill(12'h100), 4'b0001, 4'b1000);
        wait_out();
        check("mid_fe_px", 64'(px[0]), 64'h080);
        check("mid_fe_sb", 64'(fe_o), 64'h1);
        drive_beat(fill(12'h100), 4'b0000, 4'b0100);
        check("fs_noval_pending", 64'(pending), 64'h1);
        wait_out();
        check("fs_noval_val", 64'(px_val), 64'h0);
        check("fs_noval_px", 64'(px), 64'h0);
        drive_beat(fill(12'h100), 4'b0001, 4'b0100);
        check("apply_pending_clr", 64'(pending), 64'h0);
        wait_out();
        check("apply_px", 64'(px[0]), 64'h900);

        // 6. Write coincident with apply beat
        write_coef(kctr(8'h20));
        coef    = kctr(8'h10);
        coef_wr = 1'b1;
        drive_beat(fill(12'h100), 4'b0001, 4'b0100);
        coef_wr = 1'b0;
        check("coinc_pending", 64'(pending), 64'h1);
        wait_out();
        check("coinc_old_applied", 64'(px[0]), 64'h200);
        drive_beat(fill(12'h100), 4'b0001, 4'b0100);
        check("coinc_next_clr", 64'(pending), 64'h0);
        wait_out();
        check("coinc_new_applied", 64'(px[0]), 64'h100);

        // 7. Async reset mid-frame drops both kernels
        write_coef(kall(8'h10));
        drive_beat(fill(12'h100), 4'b0001, 4'b0100);
        wait_out();
        check("pre_rst_box", 64'(px[0]), 64'h900);
        write_coef(kctr(8'h20));
        drive_beat(fill(12'h100), 4'b0001, 4'b0011);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_px", 64'(px), 64'h0);
        check("midrst_val", 64'(px_val), 64'h0);
        check("midrst_pending", 64'(pending), 64'h0);
        check("midrst_sb", 64'({fe_o, fs_o, le_o, ls_o}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_beat(fill(12'h100), 4'b0001, 4'b0000);
        wait_out();
        check("postrst_ident", 64'(px[0]), 64'h100);
        check("postrst_pending", 64'(pending), 64'h0);

        // 8. Lane valid mask
        drive_beat(fill(12'h100), 4'b0101, 4'b0000);
        wait_out();
        check("mask_val", 64'(px_val), 64'h5);
        check("mask_px", 64'(px), {16'h0, 12'h000, 12'h100, 12'h000, 12'h100});

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
